// File: rtl/sauria_axi4_lite_cfg_arbiter.sv
// sauria_axi4_lite_cfg_arbiter
// Round-robin arbiter that lets NUM_REQ AXI4-Lite masters share the single
// SAURIA configuration slave port. Exactly one transaction (AW+W+B or AR+R)
// is in flight at a time. The master-side signals are pure muxes of the
// granted requester; nothing is buffered, and responses pass through unchanged.
`timescale 1ns/1ps
module sauria_axi4_lite_cfg_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW     = DATA_W / 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    // requester side
    input  logic [NUM_REQ-1:0]        s_awvalid,
    output logic [NUM_REQ-1:0]        s_awready,
    input  logic [NUM_REQ*ADDR_W-1:0] s_awaddr,
    input  logic [NUM_REQ-1:0]        s_wvalid,
    output logic [NUM_REQ-1:0]        s_wready,
    input  logic [NUM_REQ*DATA_W-1:0] s_wdata,
    input  logic [NUM_REQ*SW-1:0]     s_wstrb,
    output logic [NUM_REQ-1:0]        s_bvalid,
    input  logic [NUM_REQ-1:0]        s_bready,
    output logic [1:0]                s_bresp,
    input  logic [NUM_REQ-1:0]        s_arvalid,
    output logic [NUM_REQ-1:0]        s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
    output logic [NUM_REQ-1:0]        s_rvalid,
    input  logic [NUM_REQ-1:0]        s_rready,
    output logic [DATA_W-1:0]         s_rdata,
    output logic [1:0]                s_rresp,
    // config slave side
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [SW-1:0]             m_wstrb,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [1:0]                m_bresp,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ADDR_W-1:0]         m_araddr,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    // status
    output logic [GW-1:0]             o_grant_id,
    output logic                      o_busy
);

    typedef enum logic [2:0] {IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;

    logic [NUM_REQ-1:0] req;
    logic               pick_vld;
    logic [GW-1:0]      pick_id;
    logic [GW-1:0]      next_ptr;
    int                 g_idx;

    // A write-data beat on its own never opens a transaction.
    assign req        = s_awvalid | s_arvalid;
    assign g_idx      = int'(grant_q);
    assign next_ptr   = (g_idx == NUM_REQ - 1) ? '0 : grant_q + GW'(1);
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q != IDLE);

    // Round-robin scan starting at rr_ptr; the loop runs backwards so the
    // nearest requester to rr_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_id  = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = GW'(idx);
            end
        end
    end

    // Next-state and channel routing for the granted requester.
    always_comb begin
        logic aw_fin;
        logic w_fin;
        aw_fin    = 1'b0;
        w_fin     = 1'b0;
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_arready = '0;
        s_rvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        m_awaddr  = s_awaddr[g_idx*ADDR_W +: ADDR_W];
        m_wdata   = s_wdata[g_idx*DATA_W +: DATA_W];
        m_wstrb   = s_wstrb[g_idx*SW +: SW];
        m_araddr  = s_araddr[g_idx*ADDR_W +: ADDR_W];
        s_bresp   = m_bresp;
        s_rdata   = m_rdata;
        s_rresp   = m_rresp;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_id;
                    state_d = s_awvalid[pick_id] ? WR_XFER : RD_ADDR;
                end
            end
            WR_XFER: begin
                m_awvalid          = s_awvalid[grant_q] & ~aw_done_q;
                s_awready[grant_q] = m_awready & ~aw_done_q;
                m_wvalid           = s_wvalid[grant_q] & ~w_done_q;
                s_wready[grant_q]  = m_wready & ~w_done_q;
                aw_fin = aw_done_q | (m_awvalid & m_awready);
                w_fin  = w_done_q | (m_wvalid & m_wready);
                if (aw_fin && w_fin) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            WR_RESP: begin
                s_bvalid[grant_q] = m_bvalid;
                m_bready          = s_bready[grant_q];
                if (m_bvalid && m_bready) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            RD_ADDR: begin
                m_arvalid          = s_arvalid[grant_q];
                s_arready[grant_q] = m_arready;
                if (m_arvalid && m_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                s_rvalid[grant_q] = m_rvalid;
                m_rready          = s_rready[grant_q];
                if (m_rvalid && m_rready) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, round-robin pointer and write-phase completion flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_sauria_axi4_lite_cfg_arbiter.sv
// Testbench for sauria_axi4_lite_cfg_arbiter: bench-side requesters and a
// memory-backed config slave, checked cycle by cycle against a transaction
// level model of ownership, round-robin order and data routing.
`timescale 1ns/1ps
module tb_sauria_axi4_lite_cfg_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0] s_awaddr, s_araddr;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic [DW-1:0]   s_rdata;
    logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic            m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [SW-1:0]   m_wstrb;
    logic [1:0]      m_bresp, m_rresp;
    logic [GW-1:0]   o_grant_id;
    logic            o_busy;

    sauria_axi4_lite_cfg_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .o_grant_id(o_grant_id), .o_busy(o_busy)
    );

    int nvec = 0;
    int nerr = 0;
    bit sl_rand, auto_en, sl_hold_r;

    // requester state
    bit            aw_pend[N], w_pend[N], b_wait[N], ar_pend[N], r_wait[N];
    int            aw_dly[N], w_dly[N], ar_dly[N], wr_left[N], rd_left[N];
    logic [AW-1:0] wr_addr[N], rd_addr[N];
    logic [DW-1:0] wr_data[N];
    logic [SW-1:0] wr_strb[N];
    logic [DW-1:0] ref_mem[8];

    // config slave state
    bit            sl_aw_got, sl_w_got, sl_b_on, sl_ar_got, sl_r_on;
    logic [AW-1:0] sl_awaddr, sl_araddr;
    logic [DW-1:0] sl_wdata;
    logic [SW-1:0] sl_wstrb;
    logic [DW-1:0] sl_mem[8];

    // ownership model
    bit md_busy, md_wr, md_aw_done, md_w_done, md_ar_done;
    int md_owner, md_ptr;

    function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
        return a[11:10];
    endfunction

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'(a[4:2]);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [SW-1:0] st);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] rq, input int ptr);
        for (int k = 0; k < N; k++) if (rq[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return {20'd0, 2'($urandom_range(0, 3)), 5'd0, 3'($urandom_range(0, 7)), 2'd0};
    endfunction

    function automatic bit any_active();
        bit a;
        a = 1'b0;
        for (int i = 0; i < N; i++) begin
            a |= aw_pend[i] | w_pend[i] | b_wait[i] | ar_pend[i] | r_wait[i];
            if (auto_en && (wr_left[i] > 0 || rd_left[i] > 0)) a = 1'b1;
        end
        return a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        for (int i = 0; i < N; i++) begin
            aw_pend[i] = 0; w_pend[i] = 0; b_wait[i] = 0; ar_pend[i] = 0; r_wait[i] = 0;
            aw_dly[i] = 0; w_dly[i] = 0; ar_dly[i] = 0; wr_left[i] = 0; rd_left[i] = 0;
            wr_addr[i] = '0; rd_addr[i] = '0; wr_data[i] = '0; wr_strb[i] = '0;
        end
        sl_aw_got = 0; sl_w_got = 0; sl_b_on = 0; sl_ar_got = 0; sl_r_on = 0;
        sl_awaddr = '0; sl_araddr = '0; sl_wdata = '0; sl_wstrb = '0;
        md_busy = 0; md_wr = 0; md_aw_done = 0; md_w_done = 0; md_ar_done = 0;
        md_owner = 0; md_ptr = 0;
    endtask

    task automatic start_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] st, input int awd, input int wd);
        wr_addr[i] = a; wr_data[i] = d; wr_strb[i] = st;
        aw_pend[i] = 1; w_pend[i] = 1; b_wait[i] = 1; aw_dly[i] = awd; w_dly[i] = wd;
    endtask

    task automatic start_rd(input int i, input logic [AW-1:0] a, input int ard);
        rd_addr[i] = a; ar_pend[i] = 1; r_wait[i] = 1; ar_dly[i] = ard;
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later, advance models.
    task automatic step();
        logic [N-1:0] rq, om, e_awr, e_wr, e_bv, e_arr, e_rv;
        logic exp_awv, exp_wv, exp_arv, exp_bph, exp_rph, e_bready, e_rready;
        logic [22:0] obs_v, exp_v;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            s_awvalid[i]         = aw_pend[i] && aw_dly[i] == 0;
            s_awaddr[i*AW +: AW] = wr_addr[i];
            s_wvalid[i]          = w_pend[i] && w_dly[i] == 0;
            s_wdata[i*DW +: DW]  = wr_data[i];
            s_wstrb[i*SW +: SW]  = wr_strb[i];
            s_arvalid[i]         = ar_pend[i] && ar_dly[i] == 0;
            s_araddr[i*AW +: AW] = rd_addr[i];
            s_bready[i]          = sl_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_rready[i]          = sl_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        m_awready = !sl_aw_got && (!sl_rand || $urandom_range(0, 1) == 1);
        m_wready  = !sl_w_got && (!sl_rand || $urandom_range(0, 1) == 1);
        m_arready = !sl_ar_got && (!sl_rand || $urandom_range(0, 1) == 1);
        if (sl_aw_got && sl_w_got && !sl_b_on) sl_b_on = !sl_rand || $urandom_range(0, 2) == 0;
        if (sl_ar_got && !sl_r_on && !sl_hold_r) sl_r_on = !sl_rand || $urandom_range(0, 2) == 0;
        m_bvalid = sl_b_on;
        m_bresp  = resp_of(sl_awaddr);
        m_rvalid = sl_r_on;
        m_rdata  = sl_mem[idx_of(sl_araddr)];
        m_rresp  = resp_of(sl_araddr);
        #1;
        om = '0;
        if (md_busy) om[md_owner] = 1'b1;
        exp_awv  = md_busy && md_wr && !md_aw_done && s_awvalid[md_owner];
        exp_wv   = md_busy && md_wr && !md_w_done && s_wvalid[md_owner];
        exp_bph  = md_busy && md_wr && md_aw_done && md_w_done;
        exp_arv  = md_busy && !md_wr && !md_ar_done && s_arvalid[md_owner];
        exp_rph  = md_busy && !md_wr && md_ar_done;
        e_awr    = (md_busy && md_wr && !md_aw_done && m_awready) ? om : '0;
        e_wr     = (md_busy && md_wr && !md_w_done && m_wready) ? om : '0;
        e_bv     = (exp_bph && m_bvalid) ? om : '0;
        e_arr    = (md_busy && !md_wr && !md_ar_done && m_arready) ? om : '0;
        e_rv     = (exp_rph && m_rvalid) ? om : '0;
        e_bready = exp_bph && s_bready[md_owner];
        e_rready = exp_rph && s_rready[md_owner];
        obs_v = {o_busy, o_grant_id, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                 s_awready, s_wready, s_bvalid, s_arready, s_rvalid};
        exp_v = {md_busy, GW'(md_owner), exp_awv, exp_wv, e_bready, exp_arv, e_rready,
                 e_awr, e_wr, e_bv, e_arr, e_rv};
        chk("ctrl", 64'(obs_v), 64'(exp_v));
        if (exp_awv) chk("m_awaddr", 64'(m_awaddr), 64'(wr_addr[md_owner]));
        if (exp_wv)  chk("m_wdata", 64'({m_wstrb, m_wdata}), 64'({wr_strb[md_owner], wr_data[md_owner]}));
        if (exp_arv) chk("m_araddr", 64'(m_araddr), 64'(rd_addr[md_owner]));
        for (int i = 0; i < N; i++) begin
            if (s_bvalid[i] && s_bready[i]) begin
                chk("s_bresp", 64'(s_bresp), 64'(resp_of(wr_addr[i])));
                ref_mem[idx_of(wr_addr[i])] = merge(ref_mem[idx_of(wr_addr[i])], wr_data[i], wr_strb[i]);
                b_wait[i] = 0;
            end
            if (s_rvalid[i] && s_rready[i]) begin
                chk("s_rdata", 64'(s_rdata), 64'(ref_mem[idx_of(rd_addr[i])]));
                chk("s_rresp", 64'(s_rresp), 64'(resp_of(rd_addr[i])));
                r_wait[i] = 0;
            end
            if (s_awvalid[i] && s_awready[i]) aw_pend[i] = 0;
            if (s_wvalid[i] && s_wready[i]) w_pend[i] = 0;
            if (s_arvalid[i] && s_arready[i]) ar_pend[i] = 0;
            if (aw_pend[i] && aw_dly[i] > 0) aw_dly[i]--;
            if (w_pend[i] && w_dly[i] > 0) w_dly[i]--;
            if (ar_pend[i] && ar_dly[i] > 0) ar_dly[i]--;
        end
        // ownership model
        if (!md_busy) begin
            rq = s_awvalid | s_arvalid;
            if (rq != '0) begin
                md_owner = rr_pick(rq, md_ptr);
                md_busy = 1; md_wr = s_awvalid[md_owner];
                md_aw_done = 0; md_w_done = 0; md_ar_done = 0;
            end
        end else if (md_wr) begin
            if (exp_bph) begin
                if (m_bvalid && s_bready[md_owner]) begin md_busy = 0; md_ptr = (md_owner + 1) % N; end
            end else begin
                if (exp_awv && m_awready) md_aw_done = 1;
                if (exp_wv && m_wready) md_w_done = 1;
            end
        end else begin
            if (exp_rph) begin
                if (m_rvalid && s_rready[md_owner]) begin md_busy = 0; md_ptr = (md_owner + 1) % N; end
            end else if (exp_arv && m_arready) md_ar_done = 1;
        end
        // config slave
        if (m_awvalid && m_awready) begin sl_aw_got = 1; sl_awaddr = m_awaddr; end
        if (m_wvalid && m_wready) begin sl_w_got = 1; sl_wdata = m_wdata; sl_wstrb = m_wstrb; end
        if (m_bvalid && m_bready) begin
            sl_mem[idx_of(sl_awaddr)] = merge(sl_mem[idx_of(sl_awaddr)], sl_wdata, sl_wstrb);
            sl_aw_got = 0; sl_w_got = 0; sl_b_on = 0;
        end
        if (m_arvalid && m_arready) begin sl_ar_got = 1; sl_araddr = m_araddr; end
        if (m_rvalid && m_rready) begin sl_ar_got = 0; sl_r_on = 0; end
        // new random traffic
        if (auto_en) begin
            for (int i = 0; i < N; i++) begin
                if (!aw_pend[i] && !w_pend[i] && !b_wait[i] && wr_left[i] > 0 && $urandom_range(0, 3) == 0) begin
                    start_wr(i, rnd_addr(), $urandom, SW'($urandom_range(1, 15)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                    wr_left[i]--;
                end
                if (!ar_pend[i] && !r_wait[i] && rd_left[i] > 0 && $urandom_range(0, 3) == 0) begin
                    start_rd(i, rnd_addr(), int'($urandom_range(0, 3)));
                    rd_left[i]--;
                end
            end
        end
    endtask

    task automatic drain(input int max);
        int c;
        c = 0;
        while ((any_active() || md_busy) && c < max) begin
            step();
            c++;
        end
        chk("drain_done", 64'(c < max), 64'(1));
    endtask

    initial begin
        int c;
        sl_rand = 0; auto_en = 0; sl_hold_r = 0;
        for (int k = 0; k < 8; k++) begin ref_mem[k] = '0; sl_mem[k] = '0; end
        reset_models();
        // reset held 3 cycles with requests and slave readies asserted
        rst = 1'b1;
        s_awvalid = '1; s_arvalid = '1; s_wvalid = '1; s_bready = '1; s_rready = '1;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        m_awready = 1; m_wready = 1; m_arready = 1; m_bvalid = 1; m_rvalid = 1;
        m_bresp = 2'd0; m_rresp = 2'd0; m_rdata = '0;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            chk("reset_out", 64'({o_busy, o_grant_id, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                                  s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 64'(0));
        end
        @(negedge clk);
        s_awvalid = '0; s_arvalid = '0; s_wvalid = '0;
        m_bvalid = 0; m_rvalid = 0;
        rst = 1'b0;

        // single write from requester 0, then read it back through requester 2
        start_wr(0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 0);
        drain(50);
        start_rd(2, 32'h0000_0100, 0);
        drain(50);

        // three simultaneous reads, including SLVERR and DECERR responses
        start_rd(0, 32'h0000_0100, 0);
        start_rd(1, 32'h0000_0804, 0);
        start_rd(2, 32'h0000_0C08, 0);
        drain(100);

        // write data offered four cycles before its address
        start_wr(1, 32'h0000_0010, 32'h1234_5678, 4'b0101, 4, 0);
        drain(60);
        start_rd(0, 32'h0000_0010, 0);
        drain(50);

        // same requester with write and read together: write goes first
        start_wr(2, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 0, 0);
        start_rd(2, 32'h0000_0014, 0);
        drain(60);

        // randomized traffic with random backpressure on both sides
        sl_rand = 1; auto_en = 1;
        for (int i = 0; i < N; i++) begin wr_left[i] = 20; rd_left[i] = 20; end
        drain(20000);
        auto_en = 0; sl_rand = 0;

        // reset while the read data phase is stalled
        sl_hold_r = 1;
        start_rd(1, 32'h0000_0018, 0);
        c = 0;
        while (!(md_busy && !md_wr && md_ar_done) && c < 20) begin step(); c++; end
        chk("reach_rd_data", 64'(c < 20), 64'(1));
        step();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_read", 64'({o_busy, o_grant_id, m_rready, m_arvalid, s_rvalid, s_arready}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        sl_hold_r = 0;
        reset_models();
        start_rd(2, 32'h0000_0100, 0);
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
